// File: rtl/tx_port_txn_scheduler.sv
// tx_port_txn_scheduler
//   Round-robin transaction scheduler between the per-channel TX port
//   monitors and the shared TX engine. One channel is granted at a time;
//   its LEN/OFF/LAST are captured and handed to the engine. The monitor is
//   acknowledged once the engine accepts. The grant is held until both the
//   channel (DONE) and the engine (ENG_DONE) report completion.
//
//   Optional build macro: TXSCHED_WATCHDOG_EN
//     defined   - a stall watchdog raises TX_ERR[g] after C_TIMEOUT-1 WAIT
//                 cycles without engine progress while DONE[g] is low
//     undefined - TX_ERR is tied low and C_TIMEOUT is unused
//
// Ports
//   CLK, RST      clock, synchronous active-high reset
//   TXN[i]        channel i has a transaction ready
//   LEN/OFF/LAST  per-channel transaction parameters (32/31/1 bits each)
//   DONE[i]       channel i has closed its transaction
//   ACK[i]        one-cycle acknowledge to the granted monitor
//   TX_ERR[i]     watchdog error to the granted monitor
//   ENG_REQ/ACK   engine request handshake
//   ENG_CHNL/LEN/OFF/LAST  granted transaction fields
//   ENG_PROGRESS  engine moved data for the current grant (pulse)
//   ENG_DONE      engine finished the current grant (pulse)
//   BUSY          a grant is outstanding
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   S_IDLE    | no grant; arbitrate among TXN from the round-robin pointer
//   S_ISSUE   | ENG_REQ high with captured fields, waiting for ENG_ACK
//   S_ACK     | ACK[g] pulse to the monitor
//   S_WAIT    | waiting for DONE[g] and ENG_DONE (sticky)
//   S_RELEASE | advance the pointer past g, clear sticky engine done
module tx_port_txn_scheduler #(
  parameter int C_NUM_CHNL   = 4,
  parameter int C_CHNL_WIDTH = $clog2(C_NUM_CHNL),
  parameter int C_TIMEOUT    = 1024
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [C_NUM_CHNL-1:0]    TXN,
  input  logic [32*C_NUM_CHNL-1:0] LEN,
  input  logic [31*C_NUM_CHNL-1:0] OFF,
  input  logic [C_NUM_CHNL-1:0]    LAST,
  input  logic [C_NUM_CHNL-1:0]    DONE,
  output logic [C_NUM_CHNL-1:0]    ACK,
  output logic [C_NUM_CHNL-1:0]    TX_ERR,
  output logic                     ENG_REQ,
  input  logic                     ENG_ACK,
  output logic [C_CHNL_WIDTH-1:0]  ENG_CHNL,
  output logic [31:0]              ENG_LEN,
  output logic [30:0]              ENG_OFF,
  output logic                     ENG_LAST,
  input  logic                     ENG_PROGRESS,
  input  logic                     ENG_DONE,
  output logic                     BUSY
);

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_ISSUE   = 5'b00010,
    S_ACK     = 5'b00100,
    S_WAIT    = 5'b01000,
    S_RELEASE = 5'b10000
  } state_e;

  state_e                  state_q;
  logic [C_CHNL_WIDTH-1:0] ptr_q;
  logic [C_CHNL_WIDTH-1:0] chnl_q;
  logic [31:0]             len_q;
  logic [30:0]             off_q;
  logic                    last_q;
  logic                    req_q;
  logic                    busy_q;
  logic                    eng_done_q;
  logic [C_NUM_CHNL-1:0]   ack_q;
  logic [C_NUM_CHNL-1:0]   grant_onehot;

  logic [C_CHNL_WIDTH-1:0] pick_idx;
  logic                    pick_vld;

  // Channel index "step" positions above base, wrapping past C_NUM_CHNL-1.
  function automatic logic [C_CHNL_WIDTH-1:0] rr_idx(
    input logic [C_CHNL_WIDTH-1:0] base,
    input int                      step
  );
    int s;
    s = int'(base) + step;
    if (s >= C_NUM_CHNL) s = s - C_NUM_CHNL;
    return C_CHNL_WIDTH'(s);
  endfunction

  // Walk from the farthest position down to the pointer so the nearest
  // requester at or above the pointer is the last one written and wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = C_NUM_CHNL - 1; i >= 0; i--) begin
      if (TXN[rr_idx(ptr_q, i)]) begin
        pick_vld = 1'b1;
        pick_idx = rr_idx(ptr_q, i);
      end
    end
  end

  assign grant_onehot = {{(C_NUM_CHNL-1){1'b0}}, 1'b1} << chnl_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      chnl_q     <= '0;
      len_q      <= '0;
      off_q      <= '0;
      last_q     <= 1'b0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      eng_done_q <= 1'b0;
      ack_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            chnl_q  <= pick_idx;
            len_q   <= LEN[32*pick_idx +: 32];
            off_q   <= OFF[31*pick_idx +: 31];
            last_q  <= LAST[pick_idx];
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ENG_DONE) eng_done_q <= 1'b1;
          if (ENG_ACK) begin
            req_q   <= 1'b0;
            ack_q   <= grant_onehot;
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          // DONE[g] is deliberately ignored here: the monitor only sees ACK
          // one cycle later, so its DONE is stale in this cycle.
          if (ENG_DONE) eng_done_q <= 1'b1;
          ack_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (ENG_DONE) eng_done_q <= 1'b1;
          if (DONE[chnl_q] && (eng_done_q || ENG_DONE)) state_q <= S_RELEASE;
        end
        S_RELEASE: begin
          ptr_q      <= (chnl_q == C_CHNL_WIDTH'(C_NUM_CHNL - 1)) ? '0 : chnl_q + 1'b1;
          eng_done_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          req_q      <= 1'b0;
          busy_q     <= 1'b0;
          eng_done_q <= 1'b0;
          ack_q      <= '0;
        end
      endcase
    end
  end

  assign ACK      = ack_q;
  assign ENG_REQ  = req_q;
  assign ENG_CHNL = chnl_q;
  assign ENG_LEN  = len_q;
  assign ENG_OFF  = off_q;
  assign ENG_LAST = last_q;
  assign BUSY     = busy_q;

`ifdef TXSCHED_WATCHDOG_EN
  localparam int                C_WD_W    = $clog2(C_TIMEOUT) + 1;
  localparam logic [C_WD_W-1:0] C_WD_LAST = C_WD_W'(C_TIMEOUT - 1);

  logic [C_WD_W-1:0]     wd_cnt_q;
  logic [C_WD_W-1:0]     wd_cnt_d;
  logic [C_NUM_CHNL-1:0] err_q;

  // Saturates at the terminal value so a long stall cannot wrap around.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (ENG_PROGRESS) wd_cnt_d = '0;
    else if (!DONE[chnl_q] && (wd_cnt_q != C_WD_LAST)) wd_cnt_d = wd_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_cnt_q <= '0;
      err_q    <= '0;
    end else if (state_q == S_ACK) begin
      wd_cnt_q <= '0;
      err_q    <= '0;
    end else if (state_q == S_WAIT) begin
      wd_cnt_q <= wd_cnt_d;
      if (wd_cnt_d == C_WD_LAST) err_q <= grant_onehot;
    end else if (state_q == S_RELEASE) begin
      err_q <= '0;
    end
  end

  assign TX_ERR = err_q;
`else
  assign TX_ERR = '0;

  // Watchdog inputs are not consumed in this build.
  logic unused_wd;
  assign unused_wd = ENG_PROGRESS ^ (C_TIMEOUT > 1);
`endif

endmodule

// File: tb/tb_tx_port_txn_scheduler.sv
module tb_tx_port_txn_scheduler;
  localparam int N = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [N-1:0]  txn = '0;
  logic [N-1:0]  last_v = '0;
  logic [N-1:0]  done_v = '0;
  logic [32*N-1:0] len_v = '0;
  logic [31*N-1:0] off_v = '0;
  logic          eng_ack = 1'b0;
  logic          eng_progress = 1'b0;
  logic          eng_done = 1'b0;

  logic [N-1:0]  ACK;
  logic [N-1:0]  TX_ERR;
  logic          ENG_REQ;
  logic [1:0]    ENG_CHNL;
  logic [31:0]   ENG_LEN;
  logic [30:0]   ENG_OFF;
  logic          ENG_LAST;
  logic          BUSY;

  int errors = 0;
  int checks = 0;
  int exp_ptr = 0;
  int cyc = 0;
  int last_req_cyc = 0;

  tx_port_txn_scheduler #(.C_NUM_CHNL(N), .C_TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST), .TXN(txn), .LEN(len_v), .OFF(off_v), .LAST(last_v),
    .DONE(done_v), .ACK(ACK), .TX_ERR(TX_ERR), .ENG_REQ(ENG_REQ), .ENG_ACK(eng_ack),
    .ENG_CHNL(ENG_CHNL), .ENG_LEN(ENG_LEN), .ENG_OFF(ENG_OFF), .ENG_LAST(ENG_LAST),
    .ENG_PROGRESS(eng_progress), .ENG_DONE(eng_done), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000ns");
    $fatal(1);
  end

  // Reference arbitration: first requester found walking upward from the
  // pointer with wrap-around.
  function automatic int model_pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++) if (m[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic randomize_fields();
    for (int c = 0; c < N; c++) begin
      len_v[32*c +: 32] = $urandom;
      off_v[31*c +: 31] = 31'($urandom);
      last_v[c] = 1'($urandom);
    end
  endtask

  task automatic apply_reset(input int ncyc);
    @(negedge CLK);
    RST = 1'b1; txn = '0; done_v = '0; eng_ack = 0; eng_progress = 0; eng_done = 0;
    repeat (ncyc) @(negedge CLK);
    RST = 1'b0;
    exp_ptr = 0;
  endtask

  task automatic wait_req(output bit got);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (ENG_REQ === 1'b1) got = 1;
    end
    if (got) last_req_cyc = cyc;
  endtask

  // One full grant: arbitration, optional backpressure, ACK, completion.
  task automatic do_grant(input int ack_delay, input int done_delay, input bit keep_txn,
                          input bit scramble, input bit eng_early);
    int ch; bit got; bit early;
    logic [31:0] e_len; logic [30:0] e_off; logic e_last;
    early = eng_early && (done_delay >= 2);
    ch = model_pick(txn, exp_ptr);
    wait_req(got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL req_timeout: ENG_REQ=%b, required 1 within 20 cycles", ENG_REQ);
      return;
    end
    e_len = len_v[32*ch +: 32]; e_off = off_v[31*ch +: 31]; e_last = last_v[ch];
    checks++; if (ENG_CHNL !== 2'(ch)) begin errors++; $display("FAIL grant_chnl: got %0d required %0d", ENG_CHNL, ch); end
    checks++; if (ENG_LEN !== e_len) begin errors++; $display("FAIL grant_len: got %0h required %0h", ENG_LEN, e_len); end
    checks++; if (ENG_OFF !== e_off || ENG_LAST !== e_last) begin errors++; $display("FAIL grant_off_last: got %0h/%b required %0h/%b", ENG_OFF, ENG_LAST, e_off, e_last); end
    checks++; if (BUSY !== 1'b1 || ACK !== '0) begin errors++; $display("FAIL issue_busy_ack: got busy=%b ack=%b required 1/0000", BUSY, ACK); end
    if (scramble) begin
      txn[ch] = 1'b0; len_v[32*ch +: 32] = $urandom; off_v[31*ch +: 31] = 31'($urandom); last_v[ch] = ~last_v[ch];
    end
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge CLK);
      checks++;
      if (ENG_REQ !== 1'b1 || ACK !== '0 || ENG_CHNL !== 2'(ch) || ENG_LEN !== e_len || ENG_OFF !== e_off || ENG_LAST !== e_last) begin
        errors++; $display("FAIL backpressure_hold: got req=%b ack=%b chnl=%0d len=%0h required 1/0000/%0d/%0h", ENG_REQ, ACK, ENG_CHNL, ENG_LEN, ch, e_len);
      end
    end
    eng_ack = 1'b1;
    @(negedge CLK);
    eng_ack = 1'b0;
    checks++; if (ACK !== 4'(1 << ch) || ENG_REQ !== 1'b0) begin errors++; $display("FAIL ack_pulse: got ack=%b req=%b required %b/0", ACK, ENG_REQ, 4'(1 << ch)); end
    if (!keep_txn) txn[ch] = 1'b0;
    for (int i = 0; i < done_delay; i++) begin
      @(negedge CLK);
      checks++;
      if (BUSY !== 1'b1 || ACK !== '0 || ENG_CHNL !== 2'(ch)) begin
        errors++; $display("FAIL wait_state: got busy=%b ack=%b chnl=%0d required 1/0000/%0d", BUSY, ACK, ENG_CHNL, ch);
      end
      eng_done = early && (i == 0);
      if (!early && done_delay >= 2 && i == done_delay - 2) done_v[ch] = 1'b1;
    end
    done_v[ch] = 1'b1; eng_done = !early;
    @(negedge CLK);
    done_v[ch] = 1'b0; eng_done = 1'b0;
    checks++; if (BUSY !== 1'b1 || ENG_CHNL !== 2'(ch)) begin errors++; $display("FAIL release_state: got busy=%b chnl=%0d required 1/%0d", BUSY, ENG_CHNL, ch); end
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0 || TX_ERR !== '0) begin errors++; $display("FAIL back_to_idle: got busy=%b tx_err=%b required 0/0000", BUSY, TX_ERR); end
    exp_ptr = (ch + 1) % N;
  endtask

  task automatic test_reset();
    apply_reset(2);
    checks++; if (ACK !== '0)      begin errors++; $display("FAIL rst_ack: got %b required 0000", ACK); end
    checks++; if (TX_ERR !== '0)   begin errors++; $display("FAIL rst_tx_err: got %b required 0000", TX_ERR); end
    checks++; if (ENG_REQ !== 1'b0) begin errors++; $display("FAIL rst_eng_req: got %b required 0", ENG_REQ); end
    checks++; if (ENG_CHNL !== '0) begin errors++; $display("FAIL rst_eng_chnl: got %0d required 0", ENG_CHNL); end
    checks++; if (ENG_LEN !== '0)  begin errors++; $display("FAIL rst_eng_len: got %0h required 0", ENG_LEN); end
    checks++; if (ENG_OFF !== '0)  begin errors++; $display("FAIL rst_eng_off: got %0h required 0", ENG_OFF); end
    checks++; if (ENG_LAST !== 1'b0) begin errors++; $display("FAIL rst_eng_last: got %b required 0", ENG_LAST); end
    checks++; if (BUSY !== 1'b0)   begin errors++; $display("FAIL rst_busy: got %b required 0", BUSY); end
  endtask

  task automatic test_single();
    apply_reset(1);
    randomize_fields();
    len_v[32*2 +: 32] = 32'd8;
    txn = 4'b0100;
    do_grant(0, 4, 0, 0, 0);
  endtask

  task automatic test_round_robin();
    int prev;
    apply_reset(1);
    randomize_fields();
    txn = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      prev = last_req_cyc;
      do_grant(0, 1, 1, 0, 0);
      if (g > 0) begin
        checks++;
        if (last_req_cyc - prev != 5) begin errors++; $display("FAIL rr_turnaround: got %0d cycles required 5", last_req_cyc - prev); end
      end
    end
    checks++; if (exp_ptr != 1) begin errors++; $display("FAIL rr_order_end: got next pointer %0d required 1", exp_ptr); end
    txn = '0;
  endtask

  task automatic test_zero_length();
    bit got;
    apply_reset(1);
    randomize_fields();
    len_v[32*1 +: 32] = 32'd0;
    txn = 4'b0010;
    wait_req(got);
    checks++; if (!got || ENG_CHNL !== 2'd1 || ENG_LEN !== 32'd0) begin errors++; $display("FAIL zl_issue: got req=%b chnl=%0d len=%0h required 1/1/0", ENG_REQ, ENG_CHNL, ENG_LEN); end
    eng_ack = 1'b1; eng_done = 1'b1;
    @(negedge CLK);
    eng_ack = 1'b0; eng_done = 1'b0;
    checks++; if (ACK !== 4'b0010) begin errors++; $display("FAIL zl_ack: got %b required 0010", ACK); end
    done_v[1] = 1'b1; txn = '0;
    @(negedge CLK);
    checks++; if (ACK !== '0 || BUSY !== 1'b1) begin errors++; $display("FAIL zl_wait_entry: got ack=%b busy=%b required 0000/1", ACK, BUSY); end
    @(negedge CLK);
    checks++; if (ACK !== '0 || BUSY !== 1'b1) begin errors++; $display("FAIL zl_release: got ack=%b busy=%b required 0000/1", ACK, BUSY); end
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL zl_idle: got busy=%b required 0", BUSY); end
    done_v = '0;
  endtask

  task automatic test_backpressure();
    apply_reset(1);
    randomize_fields();
    txn = 4'($urandom_range(1, 15));
    do_grant(10, 3, 0, 1, 0);
  endtask

  task automatic test_random();
    apply_reset(1);
    for (int it = 0; it < 12; it++) begin
      randomize_fields();
      txn = txn | 4'($urandom_range(0, 15));
      if (txn == '0) txn = 4'(1 << $urandom_range(0, 3));
      do_grant($urandom_range(0, 3), $urandom_range(1, 6), 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    txn = '0;
  endtask

  task automatic test_watchdog();
    bit got;
    logic [N-1:0] e_err;
`ifdef TXSCHED_WATCHDOG_EN
    e_err = 4'b1000;
`else
    e_err = 4'b0000;
`endif
    for (int run = 0; run < 2; run++) begin
      apply_reset(1);
      randomize_fields();
      txn = 4'b1000;
      wait_req(got);
      checks++; if (!got) begin errors++; $display("FAIL wd_req: got req=%b required 1", ENG_REQ); end
      eng_ack = 1'b1;
      @(negedge CLK);
      eng_ack = 1'b0; txn = '0;
      for (int j = 1; j <= 40; j++) begin
        @(negedge CLK);
        if (run == 0) begin
          if (j == 15) begin checks++; if (TX_ERR !== '0) begin errors++; $display("FAIL wd_before: got %b required 0000", TX_ERR); end end
          if (j == 16 || j == 30) begin checks++; if (TX_ERR !== e_err) begin errors++; $display("FAIL wd_expire: cycle %0d got %b required %b", j, TX_ERR, e_err); end end
        end else begin
          checks++; if (TX_ERR !== '0) begin errors++; $display("FAIL wd_progress: cycle %0d got %b required 0000", j, TX_ERR); end
          eng_progress = (j % 8 == 0);
        end
      end
      eng_progress = 1'b0;
      checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL wd_held: got busy=%b required 1", BUSY); end
      done_v[3] = 1'b1; eng_done = 1'b1;
      @(negedge CLK);
      done_v[3] = 1'b0; eng_done = 1'b0;
      @(negedge CLK);
      checks++; if (BUSY !== 1'b0 || TX_ERR !== '0) begin errors++; $display("FAIL wd_release: got busy=%b tx_err=%b required 0/0000", BUSY, TX_ERR); end
    end
  endtask

  task automatic test_reset_mid_wait();
    bit got;
    apply_reset(1);
    randomize_fields();
    txn = 4'b0010;
    do_grant(0, 2, 0, 0, 0);
    txn = 4'b0100;
    wait_req(got);
    checks++; if (!got || ENG_CHNL !== 2'd2) begin errors++; $display("FAIL rmw_grant: got req=%b chnl=%0d required 1/2", ENG_REQ, ENG_CHNL); end
    eng_ack = 1'b1;
    @(negedge CLK);
    eng_ack = 1'b0; txn = 4'b0101;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++;
    if ({ACK, TX_ERR, ENG_REQ, ENG_CHNL, ENG_LEN, ENG_OFF, ENG_LAST, BUSY} !== '0) begin
      errors++; $display("FAIL rmw_outputs: got ack=%b err=%b req=%b chnl=%0d len=%0h off=%0h last=%b busy=%b required all 0",
                         ACK, TX_ERR, ENG_REQ, ENG_CHNL, ENG_LEN, ENG_OFF, ENG_LAST, BUSY);
    end
    exp_ptr = 0;
    do_grant(0, 1, 0, 0, 0);
    checks++; if (exp_ptr != 1) begin errors++; $display("FAIL rmw_winner: next pointer %0d required 1", exp_ptr); end
    txn = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_length();
    test_backpressure();
    test_random();
    test_watchdog();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
